// File: rtl/pipe_stage_with_valid.sv
// One stage of the elastic delay line: a valid flag plus a payload register.
// The valid flag follows its source whenever the stage is allowed to advance,
// while the payload only updates when a real beat arrives. This lets empty
// stages keep stale data instead of toggling the payload on every bubble.
module pipe_stage_with_valid #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             adv,
    input  logic             src_vld,
    input  logic [width-1:0] src_data,
    output logic             vld,
    output logic [width-1:0] data
);

    // Flush clears occupancy but leaves the payload alone; advancing copies the source beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (adv) begin
            vld <= src_vld;
            if (src_vld) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/elastic_shift_register_with_valid.sv
// Stallable delay line with ready/valid handshakes on both ends.
// Beats move one stage per cycle toward the output. A stage may advance when
// the stage ahead of it advances or is empty, so bubbles collapse while the
// output is stalled and the input only backs up once every stage is occupied.
module elastic_shift_register_with_valid #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [width-1:0]             in_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [width-1:0]             out_data,
    output logic [$clog2(depth+1)-1:0]   occupancy
);

    localparam int OccW = $clog2(depth + 1);

    logic [depth-1:0] vld;
    logic [depth-1:0] adv;
    logic [depth-1:0] src_vld;
    logic [width-1:0] data     [depth];
    logic [width-1:0] src_data [depth];
    logic [OccW-1:0]  occ_count;

    // Stage 0 is fed from the input port, every later stage from its predecessor
    for (genvar i = 0; i < depth; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign src_vld[i]  = in_vld;
            assign src_data[i] = in_data;
        end else begin : g_body
            assign src_vld[i]  = vld[i-1];
            assign src_data[i] = data[i-1];
        end

        pipe_stage_with_valid #(
            .width (width)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .adv      (adv[i]),
            .src_vld  (src_vld[i]),
            .src_data (src_data[i]),
            .vld      (vld[i]),
            .data     (data[i])
        );
    end

    // Advance permission ripples backwards from the output: a stage may load if it is empty or the next one moves
    always_comb begin
        adv          = '0;
        adv[depth-1] = out_rdy | ~vld[depth-1];
        for (int i = depth - 2; i >= 0; i--) begin
            adv[i] = adv[i+1] | ~vld[i];
        end
    end

    // Occupancy is simply the number of stages currently holding a beat
    always_comb begin
        occ_count = '0;
        for (int i = 0; i < depth; i++) begin
            occ_count = occ_count + OccW'(vld[i]);
        end
    end

    assign in_rdy    = adv[0] & ~flush;
    assign out_vld   = vld[depth-1] & ~flush;
    assign out_data  = data[depth-1];
    assign occupancy = occ_count;

endmodule

// File: tb/tb_elastic_shift_register_with_valid.sv
// Self-checking bench for the elastic shift register.
// Three instances (depth 4 / width 8, depth 1 / width 1, depth 8 / width 32)
// share clock and reset; only one is exercised at a time. The reference model
// is a queue of beats tagged with the edge at which they were accepted: the
// oldest beat reaches the output exactly depth edges after acceptance because
// nothing is ever ahead of it, and the input is ready whenever the pipe is not
// full or the output is draining.
module tb_elastic_shift_register_with_valid;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [2:0]  in_vld;
    logic [2:0]  out_rdy;
    logic [2:0]  flush;
    logic [31:0] in_data [3];
    logic [2:0]  in_rdy;
    logic [2:0]  out_vld;
    logic [31:0] obs_data [3];
    logic [31:0] obs_occ  [3];

    logic [7:0]  od0;
    logic [0:0]  od1;
    logic [31:0] od2;
    logic [2:0]  oc0;
    logic [0:0]  oc1;
    logic [3:0]  oc2;

    assign obs_data[0] = {24'h0, od0};
    assign obs_data[1] = {31'h0, od1};
    assign obs_data[2] = od2;
    assign obs_occ[0]  = {29'h0, oc0};
    assign obs_occ[1]  = {31'h0, oc1};
    assign obs_occ[2]  = {28'h0, oc2};

    elastic_shift_register_with_valid #(.width(8), .depth(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]),
        .in_vld(in_vld[0]), .in_rdy(in_rdy[0]), .in_data(in_data[0][7:0]),
        .out_vld(out_vld[0]), .out_rdy(out_rdy[0]), .out_data(od0), .occupancy(oc0)
    );

    elastic_shift_register_with_valid #(.width(1), .depth(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]),
        .in_vld(in_vld[1]), .in_rdy(in_rdy[1]), .in_data(in_data[1][0:0]),
        .out_vld(out_vld[1]), .out_rdy(out_rdy[1]), .out_data(od1), .occupancy(oc1)
    );

    elastic_shift_register_with_valid #(.width(32), .depth(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .flush(flush[2]),
        .in_vld(in_vld[2]), .in_rdy(in_rdy[2]), .in_data(in_data[2]),
        .out_vld(out_vld[2]), .out_rdy(out_rdy[2]), .out_data(od2), .occupancy(oc2)
    );

    typedef struct {
        logic [31:0] d;
        int          t;
    } beat_t;

    beat_t mq[$];
    int    edges   = 0;
    int    sel_cur = 0;
    int    passed  = 0;
    int    total   = 0;

    function automatic int depth_of(input int s);
        return (s == 0) ? 4 : ((s == 1) ? 1 : 8);
    endfunction

    function automatic logic [31:0] mask_of(input int s);
        return (s == 0) ? 32'h0000_00ff : ((s == 1) ? 32'h0000_0001 : 32'hffff_ffff);
    endfunction

    // Oldest beat is visible once depth edges have passed since its acceptance
    function automatic logic exp_out_vld();
        return !flush[sel_cur] && (mq.size() > 0) && ((edges - mq[0].t) >= depth_of(sel_cur));
    endfunction

    function automatic logic exp_in_rdy();
        return !flush[sel_cur] && ((mq.size() < depth_of(sel_cur)) || out_rdy[sel_cur]);
    endfunction

    task automatic drive(input int s, input logic v, input logic r, input logic f, input logic [31:0] d);
        sel_cur = s;
        in_vld  = '0;
        out_rdy = '0;
        flush   = '0;
        for (int i = 0; i < 3; i++) in_data[i] = '0;
        in_vld[s]  = v;
        out_rdy[s] = r;
        flush[s]   = f;
        in_data[s] = d;
    endtask

    // Update the reference model for the coming edge, then step past it
    task automatic tick();
        logic  pop;
        logic  push;
        beat_t b;
        pop  = exp_out_vld() && out_rdy[sel_cur];
        push = in_vld[sel_cur] && exp_in_rdy();
        if (flush[sel_cur]) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                b.d = in_data[sel_cur] & mask_of(sel_cur);
                b.t = edges;
                mq.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        for (int s = 0; s < 3; s++) begin
            total++; if (out_vld[s] !== 1'b0) $display("[TB] FAIL por_out_vld inst %0d: got %b expected 0", s, out_vld[s]); else passed++;
            total++; if (in_rdy[s] !== 1'b1) $display("[TB] FAIL por_in_rdy inst %0d: got %b expected 1", s, in_rdy[s]); else passed++;
            total++; if (obs_occ[s] !== 32'h0) $display("[TB] FAIL por_occupancy inst %0d: got %0d expected 0", s, obs_occ[s]); else passed++;
            total++; if (obs_data[s] !== 32'h0) $display("[TB] FAIL por_out_data inst %0d: got %h expected 0", s, obs_data[s]); else passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
        edges = 0;

        // Three beats in flight, then reset asserted between clock edges
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 1'b0, 1'b0, $urandom);
            tick();
        end
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        total++; if (obs_occ[0] !== 32'd3) $display("[TB] FAIL inflight_occupancy: got %0d expected 3", obs_occ[0]); else passed++;
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (out_vld[0] !== 1'b0) $display("[TB] FAIL async_reset_out_vld: got %b expected 0", out_vld[0]); else passed++;
        total++; if (obs_occ[0] !== 32'h0) $display("[TB] FAIL async_reset_occupancy: got %0d expected 0", obs_occ[0]); else passed++;
        total++; if (in_rdy[0] !== 1'b1) $display("[TB] FAIL async_reset_in_rdy: got %b expected 1", in_rdy[0]); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        @(posedge clk);
        #1;
        edges++;

        // Discarded beats must never show up at the output
        for (int k = 0; k < 8; k++) begin
            drive(0, 1'b0, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
            total++; if (out_vld[0] !== 1'b0) $display("[TB] FAIL reset_discard cycle %0d: out_vld got %b expected 0", k, out_vld[0]); else passed++;
            tick();
        end
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 20; k++) begin
            drive(0, k < 16, 1'b1, 1'b0, 32'(k + 1));
            @(negedge clk);
            total++; if (in_rdy[0] !== 1'b1) $display("[TB] FAIL stream_in_rdy cycle %0d: got %b expected 1", k, in_rdy[0]); else passed++;
            total++; if (out_vld[0] !== (k >= 4)) $display("[TB] FAIL stream_out_vld cycle %0d: got %b expected %b", k, out_vld[0], k >= 4); else passed++;
            if (k >= 4) begin
                total++; if (obs_data[0] !== 32'(k - 3)) $display("[TB] FAIL stream_out_data cycle %0d: got %h expected %h", k, obs_data[0], k - 3); else passed++;
            end
            tick();
        end
    endtask

    task automatic test_bubble_collapse();
        logic [7:0] beats [4];
        logic [7:0] d;
        logic       v;
        int         n = 0;
        for (int c = 0; c < 13; c++) begin
            v = (c % 3 == 0);
            d = 8'($urandom);
            drive(0, v, 1'b0, 1'b0, {24'h0, d});
            @(negedge clk);
            total++; if (obs_occ[0] !== 32'(n)) $display("[TB] FAIL bubble_occupancy cycle %0d: got %0d expected %0d", c, obs_occ[0], n); else passed++;
            total++; if (in_rdy[0] !== (n < 4)) $display("[TB] FAIL bubble_in_rdy cycle %0d: got %b expected %b", c, in_rdy[0], n < 4); else passed++;
            if (v && n < 4) begin
                beats[n] = d;
                n++;
            end
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'b0, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
            total++; if (out_vld[0] !== (k < 4)) $display("[TB] FAIL bubble_drain_vld beat %0d: got %b expected %b", k, out_vld[0], k < 4); else passed++;
            if (k < 4) begin
                total++; if (obs_data[0] !== {24'h0, beats[k]}) $display("[TB] FAIL bubble_drain_data beat %0d: got %h expected %h", k, obs_data[0], beats[k]); else passed++;
            end
            tick();
        end
    endtask

    task automatic test_full_simultaneous();
        logic [7:0] beats [9];
        for (int c = 0; c < 4; c++) begin
            beats[c] = 8'($urandom);
            drive(0, 1'b1, 1'b0, 1'b0, {24'h0, beats[c]});
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            beats[4 + k] = 8'($urandom);
            drive(0, 1'b1, 1'b1, 1'b0, {24'h0, beats[4 + k]});
            @(negedge clk);
            total++; if (in_rdy[0] !== 1'b1) $display("[TB] FAIL full_in_rdy cycle %0d: got %b expected 1", k, in_rdy[0]); else passed++;
            total++; if (obs_occ[0] !== 32'd4) $display("[TB] FAIL full_occupancy cycle %0d: got %0d expected 4", k, obs_occ[0]); else passed++;
            total++; if (out_vld[0] !== 1'b1) $display("[TB] FAIL full_out_vld cycle %0d: got %b expected 1", k, out_vld[0]); else passed++;
            total++; if (obs_data[0] !== {24'h0, beats[k]}) $display("[TB] FAIL full_out_data cycle %0d: got %h expected %h", k, obs_data[0], beats[k]); else passed++;
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'b0, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
            total++; if (out_vld[0] !== (k < 4)) $display("[TB] FAIL full_drain_vld beat %0d: got %b expected %b", k, out_vld[0], k < 4); else passed++;
            if (k < 4) begin
                total++; if (obs_data[0] !== {24'h0, beats[5 + k]}) $display("[TB] FAIL full_drain_data beat %0d: got %h expected %h", k, obs_data[0], beats[5 + k]); else passed++;
            end
            tick();
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 3; c++) begin
            drive(0, 1'b1, 1'b0, 1'b0, $urandom);
            tick();
        end
        drive(0, 1'b1, 1'b1, 1'b1, $urandom);
        @(negedge clk);
        total++; if (in_rdy[0] !== 1'b0) $display("[TB] FAIL flush_in_rdy: got %b expected 0", in_rdy[0]); else passed++;
        total++; if (out_vld[0] !== 1'b0) $display("[TB] FAIL flush_out_vld: got %b expected 0", out_vld[0]); else passed++;
        total++; if (obs_occ[0] !== 32'd3) $display("[TB] FAIL flush_pre_occupancy: got %0d expected 3", obs_occ[0]); else passed++;
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(0, 1'b0, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
            total++; if (obs_occ[0] !== 32'h0) $display("[TB] FAIL flush_post_occupancy cycle %0d: got %0d expected 0", k, obs_occ[0]); else passed++;
            total++; if (out_vld[0] !== 1'b0) $display("[TB] FAIL flush_post_out_vld cycle %0d: got %b expected 0", k, out_vld[0]); else passed++;
            tick();
        end
    endtask

    task automatic test_random(input int s, input int cycles);
        logic e_vld;
        for (int c = 0; c < cycles; c++) begin
            drive(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, $urandom);
            @(negedge clk);
            e_vld = exp_out_vld();
            total++; if (in_rdy[s] !== exp_in_rdy()) $display("[TB] FAIL rand_in_rdy inst %0d cycle %0d: got %b expected %b", s, c, in_rdy[s], exp_in_rdy()); else passed++;
            total++; if (out_vld[s] !== e_vld) $display("[TB] FAIL rand_out_vld inst %0d cycle %0d: got %b expected %b", s, c, out_vld[s], e_vld); else passed++;
            total++; if (obs_occ[s] !== 32'(mq.size())) $display("[TB] FAIL rand_occupancy inst %0d cycle %0d: got %0d expected %0d", s, c, obs_occ[s], mq.size()); else passed++;
            if (e_vld) begin
                total++; if (obs_data[s] !== mq[0].d) $display("[TB] FAIL rand_out_data inst %0d cycle %0d: got %h expected %h", s, c, obs_data[s], mq[0].d); else passed++;
            end
            tick();
        end
        // Drain so the next instance starts from an empty model
        for (int k = 0; k < depth_of(s) + 2; k++) begin
            drive(s, 1'b0, 1'b1, 1'b0, 32'h0);
            tick();
        end
        @(negedge clk);
        total++; if (obs_occ[s] !== 32'h0) $display("[TB] FAIL rand_drained inst %0d: got %0d expected 0", s, obs_occ[s]); else passed++;
        @(posedge clk);
        #1;
        edges++;
        mq.delete();
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_streaming();
        test_bubble_collapse();
        test_full_simultaneous();
        test_flush();
        test_random(0, 10000);
        test_random(1, 10000);
        test_random(2, 10000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
